// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared types and constants for the PWM peripheral.
//   pwm_cfg_t packs the five SPI configuration bytes into one 40-bit word so the
//   whole configuration can be synchronised and compared as a single value.
//   The bit order matches the concatenation
//   {duty, pwm_15_8, pwm_7_0, out_15_8, out_7_0}.
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int NUM_CH   = 16;
  localparam int PWM_BITS = 8;

  // Duty value that means "100 %": the pin never goes low.
  localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;

  typedef struct packed {
    logic [PWM_BITS-1:0] duty;
    logic [NUM_CH-1:0]   pwm_en;
    logic [NUM_CH-1:0]   out_en;
  } pwm_cfg_t;

  localparam int CFG_W = $bits(pwm_cfg_t);

  // Waveform level for one counter step. Full duty is special-cased because a
  // plain compare (cnt < 8'hFF) would leave the pin low for one step in 256.
  function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                     input logic [PWM_BITS-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_if.sv
// -----------------------------------------------------------------------------
// pwm_if
//   Bundle of the PWM peripheral's configuration input and pin-drive output.
//   master : the configuration source (SPI register file side), drives cfg and
//            observes the pins.
//   slave  : the PWM block, consumes cfg and drives out / period_start.
//   Signals:
//     cfg          - five configuration bytes as one pwm_cfg_t
//     out          - 16 pin drive bits
//     period_start - one-clock pulse on the PWM counter wrap
// -----------------------------------------------------------------------------
interface pwm_if
  import pwm_pkg::*;
  ();

  pwm_cfg_t          cfg;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  modport master (output cfg, input out, input period_start);
  modport slave  (input cfg, output out, output period_start);

endinterface

// File: rtl/pwm_cfg_sync.sv
// -----------------------------------------------------------------------------
// pwm_cfg_sync
//   Brings the configuration word from the SPI clock domain into the system
//   clock domain and only accepts it once it has been steady for a while.
//   Ports:
//     clk, rst - system clock, asynchronous active-high reset
//     cfg_in   - raw configuration word (may change at any time)
//     pending  - last configuration that was seen steady for STABLE_CYCLES
//                consecutive synchronised samples
//   Parameter:
//     STABLE_CYCLES - required run of identical synchronised samples (>= 1)
// -----------------------------------------------------------------------------
module pwm_cfg_sync
  import pwm_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  pwm_cfg_t cfg_in,
  output pwm_cfg_t pending
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  pwm_cfg_t         s1_q, s1_d;
  pwm_cfg_t         s2_q, s2_d;
  pwm_cfg_t         pending_q, pending_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;

  always_comb begin
    s1_d       = cfg_in;
    s2_d       = s1_q;
    stab_cnt_d = stab_cnt_q;
    pending_d  = pending_q;

    // Comparing s2's next value with its current one means stab_cnt_q reads 0
    // in exactly the cycle where s2 differs from its previous-cycle value.
    if (s2_d != s2_q)
      stab_cnt_d = '0;
    else if (stab_cnt_q != STABLE_MAX)
      stab_cnt_d = stab_cnt_q + 1'b1;

    // When the count sits at the limit s2 has not moved for STABLE_CYCLES
    // clocks; reloading the same value while saturated is harmless.
    if (stab_cnt_d == STABLE_MAX)
      pending_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stab_cnt_q <= '0;
      pending_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      stab_cnt_q <= stab_cnt_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//   Turns the SPI configuration bytes into 16 pin drives. Each pin is forced
//   low, driven statically high, or follows one shared 8-bit PWM waveform.
//   Ports:
//     clk, rst          - system clock, asynchronous active-high reset
//     en_reg_out_7_0    - static output enable, pins 7..0
//     en_reg_out_15_8   - static output enable, pins 15..8
//     en_reg_pwm_7_0    - PWM-mode select, pins 7..0
//     en_reg_pwm_15_8   - PWM-mode select, pins 15..8
//     pwm_duty_cycle    - shared duty (0 = off, 8'hFF = always on)
//     out               - registered pin drive
//     period_start      - one-clock pulse when the PWM counter wraps 255 -> 0
//   Parameters:
//     CLK_DIV        - system clocks per PWM counter step (>= 1)
//     STABLE_CYCLES  - steady synchronised samples before a config is accepted
// -----------------------------------------------------------------------------
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV       = 13,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [7:0]        pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

  // ---------------------------------------------------------------------------
  // Configuration crossing and filtering
  // ---------------------------------------------------------------------------
  pwm_cfg_t cfg_in;
  pwm_cfg_t pending;

  assign cfg_in = '{duty:   pwm_duty_cycle,
                    pwm_en: {en_reg_pwm_15_8, en_reg_pwm_7_0},
                    out_en: {en_reg_out_15_8, en_reg_out_7_0}};

  pwm_cfg_sync #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_cfg_sync (
    .clk    (clk),
    .rst    (rst),
    .cfg_in (cfg_in),
    .pending(pending)
  );

  // ---------------------------------------------------------------------------
  // Prescaler, PWM counter, active settings, pin drive
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0]   act_pwm_en_q, act_pwm_en_d;
  logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
  logic [NUM_CH-1:0]   out_q, out_d;

  logic                tick;
  logic                wrap;
  logic                lvl;
  logic [NUM_CH-1:0]   act_out_en;

  // Enables carry no waveform timing, so they follow the pending config
  // straight away; only the registered pin drive adds a clock.
  assign act_out_en = pending.out_en;

  always_comb begin
    tick = (div_cnt_q == DIV_LAST);
    wrap = tick && (pwm_cnt_q == CNT_LAST);
    lvl  = pwm_level(pwm_cnt_q, act_duty_q);

    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;

    // PWM select and duty change only on the wrap so a period is never cut
    // short or stretched. A pending update landing on that same edge is not
    // seen here and waits for the following wrap.
    act_pwm_en_d = act_pwm_en_q;
    act_duty_d   = act_duty_q;
    if (wrap) begin
      act_pwm_en_d = pending.pwm_en;
      act_duty_d   = pending.duty;
    end

    // Enabled pins are high unless in PWM mode, where they follow lvl.
    out_d = act_out_en & (~act_pwm_en_q | {NUM_CH{lvl}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      act_pwm_en_q <= '0;
      act_duty_q   <= '0;
      out_q        <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      act_pwm_en_q <= act_pwm_en_d;
      act_duty_q   <= act_duty_d;
      out_q        <= out_d;
    end
  end

  assign out          = out_q;
  assign period_start = wrap;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//   Randomised and directed stimulus for pwm_peripheral with CLK_DIV=4
//   (1024-clock period) and STABLE_CYCLES=2. A reference model written in terms
//   of edge counts and input-sample history predicts out/period_start for every
//   clock; a monitor pops and compares each prediction. Directed sections also
//   measure high time per period against constants.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;
  import pwm_pkg::*;

  localparam int D   = 4;
  localparam int S   = 2;
  localparam int PER = 256 * D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dout;
  logic        dps;

  pwm_if bus();

  always #5 clk = ~clk;

  pwm_peripheral #(
    .CLK_DIV      (D),
    .STABLE_CYCLES(S)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_reg_out_7_0 (bus.cfg.out_en[7:0]),
    .en_reg_out_15_8(bus.cfg.out_en[15:8]),
    .en_reg_pwm_7_0 (bus.cfg.pwm_en[7:0]),
    .en_reg_pwm_15_8(bus.cfg.pwm_en[15:8]),
    .pwm_duty_cycle (bus.cfg.duty),
    .out            (dout),
    .period_start   (dps)
  );

  assign bus.out          = dout;
  assign bus.period_start = dps;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: n = clock edges since reset release.
  //   pwm step after edge n    = (n / D) % 256
  //   period_start after n     = n % PER == PER-1
  //   active settings load at edges where n % PER == 0
  //   pending takes sample in[k-1] at edge k if in[k-1..k-1-S] are identical
  //   out after edge n         = f(state after edge n-1)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] o;
    logic        ps;
  } exp_t;

  exp_t        exp_q[$];
  pwm_cfg_t    m_hist[$];
  pwm_cfg_t    m_pend;
  logic [15:0] m_apwm;
  logic [7:0]  m_aduty;
  int          m_n;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i <= S; i++) m_hist.push_back('0);
    m_pend  = '0;
    m_apwm  = '0;
    m_aduty = '0;
    m_n     = 0;
    exp_q.delete();
  endfunction

  initial forever begin : model
    pwm_cfg_t    smp;
    int          step;
    logic        lvl;
    logic [15:0] eo;
    bit          same;
    exp_t        e;
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else begin
      smp  = bus.cfg;
      step = (m_n / D) % 256;
      lvl  = (m_aduty == 8'hFF) ? 1'b1 : (step < int'(m_aduty));
      for (int i = 0; i < 16; i++)
        eo[i] = m_pend.out_en[i] & (m_apwm[i] ? lvl : 1'b1);
      m_n++;
      if (m_n % PER == 0) begin
        m_apwm  = m_pend.pwm_en;
        m_aduty = m_pend.duty;
      end
      same = 1'b1;
      foreach (m_hist[k]) if (m_hist[k] != m_hist[0]) same = 1'b0;
      if (same) m_pend = m_hist[S];
      m_hist.push_back(smp);
      void'(m_hist.pop_front());
      e.o  = eo;
      e.ps = (m_n % PER) == (PER - 1);
      exp_q.push_back(e);
    end
  end

  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle_out_ps", {15'd0, dout, dps}, {15'd0, e.o, e.ps});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  int   hi_cnt[4];
  logic first_hi;

  // Returns at the negedge inside the cycle where period_start is high.
  task automatic wait_ps();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dps && k < 3 * PER);
    check("ps_seen", {31'd0, dps}, 32'd1);
  endtask

  // Counts out[8] high clocks for np whole periods following a wrap. At loop
  // index chg_at the duty input toggles every clock for tog_len clocks and
  // then settles on chg_duty.
  task automatic run_periods(input int np, input int chg_at,
                             input logic [7:0] chg_duty, input int tog_len);
    for (int p = 0; p < 4; p++) hi_cnt[p] = 0;
    wait_ps();
    @(negedge clk);
    for (int i = 0; i < np * PER; i++) begin
      @(negedge clk);
      if (i == 0) first_hi = dout[8];
      hi_cnt[i / PER] += int'(dout[8]);
      if (chg_at >= 0) begin
        if (i >= chg_at && i < chg_at + tog_len) bus.cfg.duty = i[0] ? 8'h11 : 8'h99;
        else if (i == chg_at + tog_len)          bus.cfg.duty = chg_duty;
      end
    end
  endtask

  task automatic set_duty_wait(input logic [7:0] d);
    bus.cfg.duty = d;
    repeat (10) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bus.cfg = '0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out", {16'd0, dout}, 32'd0);
    check("reset_ps", {31'd0, dps}, 32'd0);

    // Static drive: 2 sync + 2 stable + 1 output register
    bus.cfg.out_en[7:0] = 8'hA5;
    repeat (4) @(negedge clk);
    check("static_4clk", {16'd0, dout}, 32'h0000);
    @(negedge clk);
    check("static_5clk", {16'd0, dout}, 32'h00A5);

    // PWM on pin 8, duty 0x40
    bus.cfg.out_en = 16'h0100;
    bus.cfg.pwm_en = 16'h0100;
    set_duty_wait(8'h40);
    run_periods(3, -1, 8'h00, 0);
    check("duty40_first_rise", {31'd0, first_hi}, 32'd1);
    for (int p = 0; p < 3; p++) check("duty40_high", hi_cnt[p], 256);

    // Endpoints
    set_duty_wait(8'h00);
    run_periods(3, -1, 8'h00, 0);
    for (int p = 0; p < 3; p++) check("duty00_high", hi_cnt[p], 0);
    set_duty_wait(8'hFF);
    run_periods(3, -1, 8'h00, 0);
    for (int p = 0; p < 3; p++) check("dutyFF_high", hi_cnt[p], PER);

    // Mid-period change 0x80 -> 0x20 at pwm step 0x30
    set_duty_wait(8'h80);
    run_periods(2, 191, 8'h20, 0);
    check("mid_cur_high", hi_cnt[0], 512);
    check("mid_next_high", hi_cnt[1], 128);

    // Pending update lands on the wrap edge: old value loads, new one waits
    set_duty_wait(8'h40);
    run_periods(3, 1019, 8'h10, 0);
    check("simul_p0", hi_cnt[0], 256);
    check("simul_p1", hi_cnt[1], 256);
    check("simul_p2", hi_cnt[2], 64);

    // Duty toggling every clock across a wrap, then settling on 0x60
    set_duty_wait(8'h40);
    run_periods(3, 1000, 8'h60, 100);
    check("unstable_p0", hi_cnt[0], 256);
    check("unstable_p1", hi_cnt[1], 256);
    check("unstable_p2", hi_cnt[2], 384);

    // Asynchronous reset with all pins high
    bus.cfg = '0;
    bus.cfg.out_en = 16'hFFFF;
    repeat (8) @(negedge clk);
    check("pre_reset_out", {16'd0, dout}, 32'hFFFF);
    bus.cfg = '0;
    #2 rst = 1'b1;
    #1 check("async_reset_out", {16'd0, dout}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_out", {16'd0, dout}, 32'd0);

    // Randomised phases, checked cycle by cycle by the model
    for (int ph = 0; ph < 24; ph++) begin
      pwm_cfg_t a, b;
      int       len, mode;
      a.out_en = 16'($urandom());
      a.pwm_en = 16'($urandom());
      a.duty   = 8'($urandom());
      b.out_en = 16'($urandom());
      b.pwm_en = 16'($urandom());
      b.duty   = 8'($urandom());
      mode = $urandom_range(0, 3);
      len  = $urandom_range(200, 1500);
      if (mode == 0) a.duty = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      if (mode == 1) begin
        int tl;
        tl = $urandom_range(5, 60);
        for (int j = 0; j < tl; j++) begin
          bus.cfg = j[0] ? b : a;
          @(negedge clk);
        end
      end
      if (mode == 2) len = $urandom_range(1, 4);
      bus.cfg = a;
      repeat (len) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
